imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer-side counterpart to the CPU's instruction memory: fills instruction memory from a byte stream, such as a UART receiver or a bench driver, before the single-cycle MIPS core runs.
- Holds the CPU in reset while loading.
- Signals completion, or an error, when the load finishes.
- Sits between the byte source and the instruction memory write port, in parallel with the core's fetch port.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity DEPTH = 2**ADDR_W words
LEN_W, 16, width of the word-count header field (fixed at 16; header is 2 bytes)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load session when idle
byte_valid  in  1  source has a byte on byte_data
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready
im_we  out  1  instruction memory write enable, one-cycle pulse per word
im_addr  out  ADDR_W  word address for the write
im_wdata  out  32  word to write
cpu_hold  out  1  drives the core's Reset; high while a session is active
busy  out  1  session in progress
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky error flag; cleared by the next accepted start
words_loaded  out  LEN_W  count of words written in the current or last session

Behaviour:
- Reset is asynchronous and active-high; the clock is Clk.
- All outputs reset to 0; FSM resets to IDLE; internal counters reset to 0.
- Stream format:
  - LEN_HI byte, then LEN_LO byte, giving N as 16-bit big-endian.
  - Then 4*N data bytes; each word is big-endian, so the first byte goes to [31:24].
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, plus CHK when the optional feature is enabled.
- IDLE:
  - byte_ready=0; bytes are ignored.
  - start=1 -> LEN_HI. On the same edge: err<=0, words_loaded<=0, busy<=1, cpu_hold<=1.
- LEN_HI / LEN_LO:
  - byte_ready=1; each accepted byte advances the state.
  - After LEN_LO is accepted:
    - N==0 -> DONE.
    - N>DEPTH -> err<=1, then IDLE with no writes; busy and cpu_hold drop.
    - Otherwise -> DATA with byte index 0, word index 0.
- DATA:
  - byte_ready=1; each accepted byte shifts into the 32-bit assembly register.
  - Byte index 0..3 wraps modulo 4; the 4th accepted byte -> WRITE.
  - Gaps in byte_valid stall with no timeout.
- WRITE (exactly 1 cycle):
  - byte_ready=0; im_we=1, im_addr=word index, im_wdata=assembled word.
  - The outputs are combinational from state/registers, or registered so that they are valid in this cycle.
  - words_loaded increments on exit.
  - If word index == N-1 -> DONE (or CHK when the feature is on); else word index+1 -> DATA.
- DONE (1 cycle): done=1, busy=0, cpu_hold=0 on exit -> IDLE.
- Load latency: 2 + 4N accepted bytes + N WRITE cycles + 1 DONE cycle after start (minimum, with no stalls).
- start while busy is ignored; it never restarts the session.
- im_addr never exceeds N-1; word index does not wrap inside a session because N<=DEPTH.
- Reset mid-session aborts at once:
  - FSM to IDLE, cpu_hold=0, im_we=0.
  - Partially written memory contents are left as they are.
- words_loaded holds its value after DONE or an error until the next start.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to CHK (byte_ready=1) and accept one checksum byte equal to the XOR of all 4N data bytes.
  - Match -> DONE.
  - Mismatch -> err<=1, no done pulse, then IDLE.
  - For N==0 the checksum byte is still required and must be 8'h00.
- Undefined: no CHK state, no checksum register; the stream ends after the data bytes.

Decomposition:
- Package imem_loader_pkg holds:
  - the state encoding constants;
  - LEN_W=16;
  - the byte-order constant, big-endian first byte -> [31:24].
- One sub-module, imem_word_packer:
  - 4-byte shift-assembly register with byte index counter;
  - inputs shift_en and clear; outputs word and full.
  - Checksum XOR accumulator lives inside it under the macro.

Test Plan:
1. start; bytes 00 02 3C 10 FF FF 36 10 00 01 ->
   - im_we pulses twice: addr0=3C10FFFF, addr1=36100001;
   - done pulse; words_loaded=2; cpu_hold high from the cycle after start until DONE exit.
2. start; header 00 00 -> no im_we; done one cycle after LEN_LO; err=0 (checksum build: send 00 first).
3. ADDR_W=8; header 01 01 (N=257) -> err=1, no im_we, busy=0; next start clears err.
4. N=1 with byte_valid toggling every other cycle and start pulsed mid-stream ->
   - start ignored; single write addr0 = bytes in order; byte_ready low during the WRITE cycle.
5. Assert Reset after 6 data bytes of N=2 -> all outputs 0 asynchronously; only addr0 written; new session loads correctly.
6. With IMEM_LOADER_CHECKSUM_EN: data 12 34 56 78, checksum 08 -> done. Same data with checksum 09 -> err=1, no done.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Build option IMEM_LOADER_CHECKSUM_EN adds the trailing-checksum state.
package imem_loader_pkg;

   localparam int LEN_W = 16;

   // First stream byte of a word lands in [31:24].
   localparam bit BYTE_ORDER_BE = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      S_CHK    = 3'd6
`endif
   } state_t;

   function automatic logic [31:0] pack_byte(input logic [31:0] word, input logic [7:0] b);
      if (BYTE_ORDER_BE) return {word[23:0], b};
      else               return {b, word[31:8]};
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four stream bytes into one 32-bit instruction word.
// With IMEM_LOADER_CHECKSUM_EN it also keeps a running XOR of every byte shifted in.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        shift_en,
   input  logic        clear,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
`ifdef IMEM_LOADER_CHECKSUM_EN
   output logic [7:0]  csum,
`endif
   output logic        full
);

   logic [1:0] idx;

   // full marks the shift that completes a word, so the caller can leave DATA on that edge.
   assign full = shift_en && (idx == 2'd3);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)         idx <= 2'd0;
      else if (clear)    idx <= 2'd0;
      else if (shift_en) idx <= idx + 2'd1;
   end

   always_ff @(posedge Clk) begin
      if (shift_en) word <= pack_byte(word, byte_data);
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)         csum <= 8'h00;
      else if (clear)    csum <= 8'h00;
      else if (shift_en) csum <= csum ^ byte_data;
   end
`endif

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a length-prefixed byte stream while holding the core in reset.
// Build option IMEM_LOADER_CHECKSUM_EN requires a trailing XOR checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  words_loaded
);

   localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

   state_t            state, state_nx;
   logic [7:0]        len_hi_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_in;
   logic [ADDR_W-1:0] widx_q;
   logic              oversize;
   logic              last_word;
   logic              pk_shift;
   logic              pk_clear;
   logic              pk_full;
   logic [31:0]       pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        pk_csum;
`endif

   assign len_in    = {len_hi_q, byte_data};
   assign oversize  = 33'(len_in) > DEPTH;
   assign last_word = (33'(widx_q) + 33'd1) == 33'(len_q);
   assign busy      = (state != S_IDLE);
   assign cpu_hold  = busy;

   imem_word_packer u_packer (
      .Clk       (Clk),
      .Reset     (Reset),
      .shift_en  (pk_shift),
      .clear     (pk_clear),
      .byte_data (byte_data),
      .word      (pk_word),
`ifdef IMEM_LOADER_CHECKSUM_EN
      .csum      (pk_csum),
`endif
      .full      (pk_full)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      byte_ready = 1'b0;
      im_we      = 1'b0;
      im_addr    = '0;
      im_wdata   = 32'h0;
      done       = 1'b0;
      pk_shift   = 1'b0;
      pk_clear   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_LEN_HI;
               pk_clear = 1'b1;
            end
         end
         S_LEN_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nx = S_LEN_LO;
         end
         S_LEN_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (len_in == '0)  state_nx = S_CHK;
`else
               if (len_in == '0)  state_nx = S_DONE;
`endif
               else if (oversize) state_nx = S_IDLE;
               else               state_nx = S_DATA;
            end
         end
         S_DATA: begin
            byte_ready = 1'b1;
            pk_shift   = byte_valid;
            if (pk_full) state_nx = S_WRITE;
         end
         S_WRITE: begin
            im_we    = 1'b1;
            im_addr  = widx_q;
            im_wdata = pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nx = last_word ? S_CHK : S_DATA;
`else
            state_nx = last_word ? S_DONE : S_DATA;
`endif
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nx = (byte_data == pk_csum) ? S_DONE : S_IDLE;
         end
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         err          <= 1'b0;
         words_loaded <= '0;
         widx_q       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  err          <= 1'b0;
                  words_loaded <= '0;
                  widx_q       <= '0;
               end
            end
            S_LEN_LO: begin
               if (byte_valid && (len_in != '0) && oversize) err <= 1'b1;
            end
            S_WRITE: begin
               words_loaded <= words_loaded + LEN_W'(1);
               widx_q       <= widx_q + ADDR_W'(1);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (byte_valid && (byte_data != pk_csum)) err <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   // Header bytes are captured only while their state accepts them.
   always_ff @(posedge Clk) begin
      if (state == S_LEN_HI && byte_valid) len_hi_q <= byte_data;
      if (state == S_LEN_LO && byte_valid) len_q    <= len_in;
   end

endmodule
